// File: rtl/dec_pkg.sv
// Shared types and helpers for the decoder error-correction stage.
package dec_pkg;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_SINGLE = 2'b01,
    ERR_DOUBLE = 2'b10
  } err_kind_e;

  localparam logic [1:0] CW_8  = 2'b00;
  localparam logic [1:0] CW_16 = 2'b01;
  localparam logic [1:0] CW_32 = 2'b10;

  // Width codes 10 and 11 both mean a 32-bit word.
  function automatic logic [5:0] cw_bits(input logic [1:0] width);
    case (width)
      CW_8:    cw_bits = 6'd8;
      CW_16:   cw_bits = 6'd16;
      default: cw_bits = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/dec_syndrome_classify.sv
// Combinational syndrome decode: classifies the error and flips the bad bit
// on a single error. Bits above the word width are cleared.
module dec_syndrome_classify
  import dec_pkg::*;
(
  input  logic [31:0] codeword_i,
  input  logic [1:0]  width_i,
  input  logic [5:0]  syndrome_i,
  output logic [31:0] data_o,
  output err_kind_e   kind_o
);

  logic [1:0]  wsel;
  logic [4:0]  ham;
  logic        par;
  logic [31:0] mask;
  logic [4:0]  flip_idx;
  logic [31:0] data_masked;

  always_comb begin
    wsel = width_i[1] ? CW_32 : width_i;
    ham  = '0;
    par  = 1'b0;
    mask = '1;
    case (wsel)
      CW_8: begin
        ham  = {2'b00, syndrome_i[2:0]};
        par  = syndrome_i[3];
        mask = 32'h0000_00FF;
      end
      CW_16: begin
        ham  = {1'b0, syndrome_i[3:0]};
        par  = syndrome_i[4];
        mask = 32'h0000_FFFF;
      end
      default: begin
        ham  = syndrome_i[4:0];
        par  = syndrome_i[5];
        mask = '1;
      end
    endcase

    data_masked = codeword_i & mask;
    // H=0 with parity set means the overall parity bit (the MSB) is the bad one.
    flip_idx = (ham != 5'd0) ? (ham - 5'd1) : 5'(cw_bits(wsel) - 6'd1);

    data_o = data_masked;
    kind_o = ERR_NONE;
    if (par) begin
      data_o = data_masked ^ (32'd1 << flip_idx);
      kind_o = ERR_SINGLE;
    end else if (ham != 5'd0) begin
      kind_o = ERR_DOUBLE;
    end
  end

endmodule

// File: rtl/dec_error_corrector.sv
// Error-correction stage: input register, classify/correct, output register,
// plus saturating statistics for corrected and double-error words.
module dec_error_corrector
  import dec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      codeword_with_errors,
  input  logic [1:0]       codeword_width,
  input  logic [5:0]       syndrome,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      data_out,
  output logic [1:0]       num_of_errors,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] dbl_cnt,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_cw_q, s1_cw_d;
  logic [1:0]       s1_width_q, s1_width_d;
  logic [5:0]       s1_syn_q, s1_syn_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_data_q, s2_data_d;
  err_kind_e        s2_kind_q, s2_kind_d;
  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] dbl_q, dbl_d;

  logic [31:0] cls_data;
  err_kind_e   cls_kind;
  logic        s2_load;
  logic        in_accept;
  logic        out_hs;

  dec_syndrome_classify u_classify (
    .codeword_i (s1_cw_q),
    .width_i    (s1_width_q),
    .syndrome_i (s1_syn_q),
    .data_o     (cls_data),
    .kind_o     (cls_kind)
  );

  assign s2_load   = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_load;
  assign in_accept = in_valid && in_ready;
  assign out_hs    = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_width_d = s1_width_q;
    s1_syn_d   = s1_syn_q;
    if (in_accept) begin
      s1_valid_d = 1'b1;
      s1_cw_d    = codeword_with_errors;
      s1_width_d = codeword_width;
      s1_syn_d   = syndrome;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_kind_d  = s2_kind_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = cls_data;
        s2_kind_d = cls_kind;
      end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    corr_d = corr_q;
    dbl_d  = dbl_q;
    if (cnt_clr) begin
      corr_d = '0;
      dbl_d  = '0;
    end else if (out_hs) begin
      if (s2_kind_q == ERR_SINGLE && corr_q != CNT_MAX) corr_d = corr_q + CNT_ONE;
      if (s2_kind_q == ERR_DOUBLE && dbl_q != CNT_MAX)  dbl_d  = dbl_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_width_q <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_kind_q  <= ERR_NONE;
      corr_q     <= '0;
      dbl_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cw_q    <= s1_cw_d;
      s1_width_q <= s1_width_d;
      s1_syn_q   <= s1_syn_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_kind_q  <= s2_kind_d;
      corr_q     <= corr_d;
      dbl_q      <= dbl_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign data_out      = s2_data_q;
  assign num_of_errors = s2_kind_q;
  assign corr_cnt      = corr_q;
  assign dbl_cnt       = dbl_q;

endmodule

// File: tb/tb_dec_error_corrector.sv
// Bench for dec_error_corrector: directed cases from the test plan plus a
// randomized run scored against an arithmetic reference model.
module tb_dec_error_corrector;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      codeword_with_errors;
  logic [1:0]       codeword_width;
  logic [5:0]       syndrome;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      data_out;
  logic [1:0]       num_of_errors;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] dbl_cnt;
  logic             cnt_clr;

  dec_error_corrector #(.CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .codeword_with_errors (codeword_with_errors),
    .codeword_width       (codeword_width),
    .syndrome             (syndrome),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .data_out             (data_out),
    .num_of_errors        (num_of_errors),
    .corr_cnt             (corr_cnt),
    .dbl_cnt              (dbl_cnt),
    .cnt_clr              (cnt_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: {code, data} derived from the width/parity/Hamming rules.
  function automatic logic [33:0] ref_model(input logic [31:0] cw, input logic [1:0] wc,
                                            input logic [5:0] syn);
    int w, k, h, p, idx, code;
    longint unsigned d;
    w = (wc == 2'b00) ? 8 : (wc == 2'b01) ? 16 : 32;
    k = (w == 8) ? 4 : (w == 16) ? 5 : 6;
    h = int'(syn) % (1 << (k - 1));
    p = (int'(syn) >> (k - 1)) % 2;
    d = cw;
    d = d % (64'd1 << w);
    if (p == 0 && h == 0) code = 0;
    else if (p == 1) begin
      code = 1;
      idx  = (h != 0) ? h - 1 : w - 1;
      d    = d ^ (64'd1 << idx);
    end else code = 2;
    return {2'(code), 32'(d)};
  endfunction

  // Scoreboard / monitor, sampled on the falling edge.
  logic [33:0] exp_q[$];
  logic [33:0] e;
  int          mc = 0, md = 0, nxfer = 0;
  logic        hold_flag = 1'b0;
  logic [31:0] hold_data;
  logic [1:0]  hold_code;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      mc = 0;
      md = 0;
      hold_flag = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_data", data_out, 32'd0);
      chk("rst_code", 32'(num_of_errors), 32'd0);
      chk("rst_corr", 32'(corr_cnt), 32'd0);
      chk("rst_dbl", 32'(dbl_cnt), 32'd0);
    end else begin
      chk("corr_cnt", 32'(corr_cnt), 32'(mc));
      chk("dbl_cnt", 32'(dbl_cnt), 32'(md));
      if (hold_flag) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", data_out, hold_data);
        chk("hold_code", 32'(num_of_errors), 32'(hold_code));
      end
      hold_flag = out_valid && !out_ready;
      hold_data = data_out;
      hold_code = num_of_errors;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("data_out", data_out, e[31:0]);
          chk("code", 32'(num_of_errors), 32'(e[33:32]));
          $display("xfer %0d data=0x%08h code=%0d", nxfer, data_out, num_of_errors);
          nxfer++;
          if (e[33:32] == 2'd1 && mc < CNT_MAX) mc++;
          if (e[33:32] == 2'd2 && md < CNT_MAX) md++;
        end
      end
      if (cnt_clr) begin
        mc = 0;
        md = 0;
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_model(codeword_with_errors, codeword_width, syndrome));
    end
  end

  task automatic push(input logic [31:0] cw, input logic [1:0] w, input logic [5:0] syn);
    int n;
    @(posedge clk); #1;
    codeword_with_errors = cw;
    codeword_width = w;
    syndrome = syn;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic xact(input logic [31:0] cw, input logic [1:0] w, input logic [5:0] syn,
                      output logic [31:0] d, output logic [1:0] k, output int lat);
    push(cw, w, syn);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    d = data_out;
    k = num_of_errors;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  k;
    int          lat;
    logic        acc;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    codeword_with_errors = '0; codeword_width = '0; syndrome = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    xact(32'h1234_5678, 2'b10, 6'd0, d, k, lat);
    chk("none_data", d, 32'h1234_5678);
    chk("none_code", 32'(k), 32'd0);
    chk("none_latency", 32'(lat), 32'd2);
    chk("none_corr", 32'(corr_cnt), 32'd0);

    xact(32'h0000_00A5, 2'b00, 6'b00_1011, d, k, lat);
    chk("s8_data", d, 32'h0000_00A1);
    chk("s8_code", 32'(k), 32'd1);
    @(negedge clk);
    chk("s8_corr", 32'(corr_cnt), 32'd1);

    xact(32'h0000_00A5, 2'b00, 6'b00_1000, d, k, lat);
    chk("s8p_data", d, 32'h0000_0025);
    chk("s8p_code", 32'(k), 32'd1);

    xact(32'hFFFF_BEEF, 2'b01, 6'b00_0101, d, k, lat);
    chk("d16_data", d, 32'h0000_BEEF);
    chk("d16_code", 32'(k), 32'd2);
    @(negedge clk);
    chk("d16_dbl", 32'(dbl_cnt), 32'd1);

    // Back-pressure: two words fill the pipe, the third waits.
    @(posedge clk); #1 out_ready = 1'b0;
    push(32'h1111_1111, 2'b10, 6'd0);
    push(32'h2222_2222, 2'b11, 6'd0);
    @(posedge clk); #1;
    codeword_with_errors = 32'h3333_3333; codeword_width = 2'b10; syndrome = 6'd0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_data", data_out, 32'h1111_1111);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out1", data_out, 32'h1111_1111);
    chk("bp_accept3", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out2", data_out, 32'h2222_2222);
    @(negedge clk);
    chk("bp_out3", data_out, 32'h3333_3333);
    chk("bp_valid3", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Saturation of the corrected counter.
    for (int i = 0; i < CNT_MAX; i++) xact(32'h0000_0F0F, 2'b01, 6'b01_0001, d, k, lat);
    @(negedge clk);
    chk("corr_sat", 32'(corr_cnt), 32'(CNT_MAX));

    // Clear in the same cycle as a single-error delivery.
    @(posedge clk); #1 out_ready = 1'b0;
    push(32'h0000_00FF, 2'b00, 6'b00_1001);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1; cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_corr", 32'(corr_cnt), 32'd0);
    chk("clr_dbl", 32'(dbl_cnt), 32'd0);

    // Reset with two words in flight.
    @(posedge clk); #1 out_ready = 1'b0;
    push(32'h4444_4444, 2'b10, 6'b10_0001);
    push(32'h5555_5555, 2'b10, 6'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("midrst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    xact(32'h0000_000F, 2'b00, 6'b00_1010, d, k, lat);
    chk("postrst_data", d, 32'h0000_000D);
    chk("postrst_code", 32'(k), 32'd1);
    chk("postrst_latency", 32'(lat), 32'd2);

    // Randomized traffic with random back-pressure and clears.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom % 4) != 0;
        codeword_with_errors = $urandom;
        codeword_width = 2'($urandom % 4);
        syndrome = 6'($urandom % 64);
      end
      out_ready = ($urandom % 4) != 0;
      cnt_clr = ($urandom % 25) == 0;
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk); #1;
    out_ready = 1'b1; cnt_clr = 1'b0;
    if (acc) in_valid = 1'b0;
    for (int i = 0; i < 10 && in_valid; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
